// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks a combinational block through every input
// vector, holds each for SETTLE+1 cycles, samples its output and assembles
// the full truth table. Optional table-vs-expected compare is built only
// when TT_COMPARE_EN is defined. The captured table port is named
// truth_table because `table` is a reserved word.
module truth_table_sequencer #(
    parameter int unsigned N      = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [(2**N)-1:0]   expected,
    input  logic                dut_y,
    output logic [N-1:0]        vec,
    output logic                busy,
    output logic                done,
    output logic [(2**N)-1:0]   truth_table,
    output logic                pass,
    output logic [N:0]          mismatch_count
);

    localparam int unsigned ROWS  = 2**N;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned MC_W  = N + 1;
    localparam logic [N-1:0] LAST_VEC = N'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [N-1:0]       vec_d;
    logic               busy_d;
    logic               done_d;
    logic [ROWS-1:0]    tbl_d;

`ifdef TT_COMPARE_EN
    logic [ROWS-1:0]    exp_q;
    logic [ROWS-1:0]    exp_d;
    logic [MC_W-1:0]    mc_q;
    logic [MC_W-1:0]    mc_d;
    logic               pass_q;
    logic               pass_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == CNT_W'(1)) state_d = S_SAMPLE;
            S_SAMPLE: state_d = (vec == LAST_VEC) ? S_DONE : S_SETTLE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath
    always_comb begin
        cnt_d  = cnt_q;
        vec_d  = vec;
        tbl_d  = truth_table;
        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d = (state_q == S_DONE);
`ifdef TT_COMPARE_EN
        exp_d  = exp_q;
        mc_d   = mc_q;
        pass_d = pass_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d = '0;
                    tbl_d = '0;
                    cnt_d = CNT_W'(SETTLE);
`ifdef TT_COMPARE_EN
                    exp_d  = expected;
                    mc_d   = '0;
                    pass_d = 1'b0;
`endif
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_SAMPLE: begin
                tbl_d[vec] = dut_y;
`ifdef TT_COMPARE_EN
                if (dut_y != exp_q[vec]) begin
                    mc_d = mc_q + MC_W'(1);
                end
`endif
                if (vec != LAST_VEC) begin
                    vec_d = vec + N'(1);
                    cnt_d = CNT_W'(SETTLE);
                end
            end
            S_DONE: begin
`ifdef TT_COMPARE_EN
                pass_d = (mc_q == '0);
`endif
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            vec         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
`ifdef TT_COMPARE_EN
            exp_q       <= '0;
            mc_q        <= '0;
            pass_q      <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            vec         <= vec_d;
            busy        <= busy_d;
            done        <= done_d;
            truth_table <= tbl_d;
`ifdef TT_COMPARE_EN
            exp_q       <= exp_d;
            mc_q        <= mc_d;
            pass_q      <= pass_d;
`endif
        end
    end

`ifdef TT_COMPARE_EN
    assign pass           = pass_q;
    assign mismatch_count = mc_q;
`else
    // Compare disabled: expected is not consumed and results read as zero
    logic unused_expected;
    assign unused_expected = ^expected;
    assign pass            = 1'b0;
    assign mismatch_count  = '0;
`endif

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

- Sequences a combinational gate-level block under test through every input combination.
- Holds each input vector for a fixed settle time, samples the block's single output, and builds the full truth table in a register.
- Optionally compares the captured table against an expected mask and reports pass/fail.
- Sits beside the lab gate modules: it drives their inputs and observes their `Y`, replacing hand-written stimulus sequences.

## Interface
Parameters:
- `N`, default 3: number of DUT inputs, legal range 1..5. The MSB of `vec` maps to the DUT's first input (A).
- `SETTLE`, default 1: cycles each vector is held before sampling, legal range 1..15.

Ports:
- `clk` in, 1: sole clock, rising edge.
- `reset` in, 1: synchronous, active-high.
- `start` in, 1: begin a sweep; sampled only in IDLE.
- `expected` in, 2^N: expected table, bit i = Y for vec==i; latched on accepted start.
- `dut_y` in, 1: DUT output.
- `vec` out, N: current DUT input vector.
- `busy` out, 1: sweep in progress.
- `done` out, 1: one-cycle pulse when the sweep completes.
- `table` out, 2^N: captured truth table, bit i = sampled `dut_y` for vec==i.
- `pass` out, 1: table matched expected; valid from `done` until the next accepted start.
- `mismatch_count` out, N+1: number of rows that differ from expected.

## Operation
States: IDLE, SETTLE, SAMPLE, DONE.

- **IDLE**
  - `busy`=0.
  - On `start`=1 at an edge:
    - `vec`←0
    - `table`←0
    - `pass`←0
    - `mismatch_count`←0
    - latch `expected`
    - settle counter←SETTLE
    - go to SETTLE
- **SETTLE**
  - `busy`=1.
  - Counter decrements each cycle; when the counter is 1, go to SAMPLE.
  - `vec` is stable throughout.
- **SAMPLE**
  - `table[vec]`←`dut_y`.
  - If compare is enabled and `dut_y`≠`expected_q[vec]`: `mismatch_count`+1.
  - If `vec`==2^N−1: go to DONE.
  - Otherwise: `vec`←`vec`+1, counter←SETTLE, go to SETTLE.
- **DONE**
  - `done`=1 for this cycle only.
  - `pass`←(final `mismatch_count`==0) when compare is enabled.
  - `busy`=0.
  - Next state is IDLE.
- **Boundary rules**
  - `start` while not in IDLE is ignored; no restart and no queuing.
  - `start` held high continuously gives back-to-back sweeps, with one IDLE cycle between DONE and the next SETTLE.
  - `vec` increments without wrapping; it holds 2^N−1 after the sweep until the next start.
  - `table`, `pass` and `mismatch_count` hold their values in IDLE until the next accepted start.
  - `expected` changing mid-sweep has no effect, because the latched copy is used.
  - `dut_y`=X at SAMPLE is stored as-is; no filtering.

## Timing
- All outputs are registered.
- **Reset values:**
  - state=IDLE
  - `vec`=0
  - `busy`=0
  - `done`=0
  - `table`=0
  - `pass`=0
  - `mismatch_count`=0
- Reset asserted mid-sweep aborts on the next edge: no `done` pulse, and all outputs go to their reset values.
- Reset has priority over `start` in the same cycle.
- **Per-vector time:**
  - SETTLE+1 cycles per vector.
  - `vec` changes on the edge that leaves SAMPLE.
  - The DUT sees each vector for exactly SETTLE+1 cycles.
- **Latency:**
  - `done` is high 2^N·(SETTLE+1)+1 cycles after the edge that accepted `start`.
  - With defaults N=3, SETTLE=1, that is 17 cycles.
  - `busy` rises on the accept edge and falls on the edge entering DONE.
- Table bit i is written on the edge at the end of the SAMPLE cycle for vec==i.

## Configuration
- Macro: `TT_COMPARE_EN`.
- **Defined:**
  - `expected` is latched and compared.
  - `mismatch_count` and `pass` behave as described above.
- **Undefined:**
  - No compare logic is built.
  - `expected` is ignored.
  - `pass` and `mismatch_count` are tied to 0.
  - The sweep, `table`, `busy`, `done` and timing are identical.

## Test plan
1. **AND3 sweep.** N=3, SETTLE=1, DUT Y=A&B&C, `expected`=8'h80, start pulse.
   - `done` after 17 cycles.
   - `table`=8'h80, `pass`=1, `mismatch_count`=0.
2. **Mismatch count.** Same DUT, `expected`=8'hC0.
   - `table`=8'h80, `pass`=0, `mismatch_count`=1.
   - Without `TT_COMPARE_EN`: `pass`=0, `mismatch_count`=0, `table`=8'h80.
3. **Long settle, N=4.** N=4, SETTLE=3, DUT Y=A^B^C^D.
   - `done` at 65 cycles.
   - `table`=16'h6996.
   - Each `vec` value is held for 4 cycles.
4. **Start handling.** Start pulsed during SETTLE at cycle 5: ignored, and `done` still at 17. Start held high continuously:
   - second sweep accepted one cycle after `done`.
   - `table` cleared to 0 at that accept.
5. **Reset mid-sweep.** Reset asserted at cycle 9 for 1 cycle.
   - Next edge: `vec`=0, `busy`=0, `table`=0, no `done` pulse.
   - A new start then completes normally in 17 cycles.
6. **N=1 edge case.** N=1, SETTLE=1, DUT Y=~A, `expected`=2'b01.
   - `done` at 5 cycles.
   - `table`=2'b01, `pass`=1, `vec` ends at 1.
